// File: rtl/hud_pkg.sv
// Shared HUD types and glyph geometry for the numbers/score glyph ROM.
package hud_pkg;

  localparam int GLYPH_W    = 10;
  localparam int GLYPH_H    = 20;
  localparam int GLYPH_BASE = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONVERT    = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the {scratch, bin} pair left by one bit.
module bcd_dabble_step
  import hud_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int SCORE_W = 14
) (
  input  logic [4*DIGITS-1:0] scratch_in,
  input  logic [SCORE_W-1:0]  bin_in,
  output logic [4*DIGITS-1:0] scratch_out,
  output logic [SCORE_W-1:0]  bin_out
);

  logic [4*DIGITS-1:0] adj_s;

  // Add-3 correction on each nibble so the following shift carries in decimal.
  always_comb begin
    adj_s = scratch_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_t'(scratch_in[4*i +: 4]) >= 4'd5) begin
        adj_s[4*i +: 4] = scratch_in[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = scratch_in[4*i +: 4];
      end
    end
  end

  assign scratch_out = {adj_s[4*DIGITS-2:0], bin_in[SCORE_W-1]};
  assign bin_out     = {bin_in[SCORE_W-2:0], 1'b0};

endmodule

// File: rtl/score_digit_sequencer.sv
// HUD score readout: binary-to-BCD conversion committed on frame boundaries,
// plus a two-stage render pipeline addressing the shared numbers glyph ROM.
module score_digit_sequencer
  import hud_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCORE_W    = 14,
  parameter int GLYPH_W    = hud_pkg::GLYPH_W,
  parameter int GLYPH_H    = hud_pkg::GLYPH_H,
  parameter int GLYPH_BASE = hud_pkg::GLYPH_BASE,
  parameter int ORIGIN_X   = 480,
  parameter int ORIGIN_Y   = 16,
  parameter int ROM_AW     = 12
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [SCORE_W-1:0]    score_in,
  input  logic                  score_load,
  input  logic                  frame_start,
  output logic                  busy,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [2:0]            rom_data,
  output logic                  pixel_on,
  output logic [2:0]            pixel_color,
  output logic [4*DIGITS-1:0]   digits_out
);

  localparam int DW       = 4 * DIGITS;
  localparam int CNT_W    = $clog2(SCORE_W + 1);
  localparam int SLOT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAX_ADDR = GLYPH_BASE + 10 * GLYPH_W * GLYPH_H - 1;
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(10 ** DIGITS - 1);

  if (MAX_ADDR >= (1 << ROM_AW)) begin : g_addr_range_chk
    $error("score_digit_sequencer: glyph addresses exceed ROM_AW");
  end

  // Clamp a new score to the largest value the readout can show.
  function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
    return (v > MAX_SCORE) ? MAX_SCORE : v;
  endfunction

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [SCORE_W-1:0]   bin_r;
  logic [DW-1:0]        scratch_r;
  logic [DW-1:0]        digits_r;
  logic                 pend_r;
  logic [SCORE_W-1:0]   pend_val_r;
  logic                 busy_r;
  logic [SCORE_W-1:0]   load_val_s;
  logic [DW-1:0]        step_scratch_s;
  logic [SCORE_W-1:0]   step_bin_s;

  assign load_val_s = saturate(score_in);

  bcd_dabble_step #(
    .DIGITS  (DIGITS),
    .SCORE_W (SCORE_W)
  ) u_step (
    .scratch_in  (scratch_r),
    .bin_in      (bin_r),
    .scratch_out (step_scratch_s),
    .bin_out     (step_bin_s)
  );

  // Conversion FSM: load, iterate double-dabble, then hold until a frame boundary.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bin_r      <= {SCORE_W{1'b0}};
      scratch_r  <= {DW{1'b0}};
      digits_r   <= {DW{1'b0}};
      pend_r     <= 1'b0;
      pend_val_r <= {SCORE_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (score_load) begin
            bin_r     <= load_val_s;
            scratch_r <= {DW{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= CONVERT;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        CONVERT: begin
          if (score_load) begin
            pend_r     <= 1'b1;
            pend_val_r <= load_val_s;
          end
          if (cnt_r == CNT_W'(SCORE_W)) begin
            state_r   <= WAIT_FRAME;
          end else begin
            scratch_r <= step_scratch_s;
            bin_r     <= step_bin_s;
            cnt_r     <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            digits_r <= scratch_r;
            // A load arriving on the commit edge is newer than any pending one.
            if (score_load || pend_r) begin
              bin_r     <= score_load ? load_val_s : pend_val_r;
              scratch_r <= {DW{1'b0}};
              cnt_r     <= {CNT_W{1'b0}};
              pend_r    <= 1'b0;
              state_r   <= CONVERT;
            end else begin
              state_r   <= IDLE;
              busy_r    <= 1'b0;
            end
          end else if (score_load) begin
            pend_r     <= 1'b1;
            pend_val_r <= load_val_s;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          pend_r  <= 1'b0;
        end
      endcase
    end
  end

  logic                 in_box_s;
  logic [9:0]           dx_s;
  logic [9:0]           dy_s;
  logic [9:0]           base_s;
  logic [9:0]           col_s;
  logic [SLOT_W-1:0]    slot_s;
  bcd_t                 digit_s;
  logic                 lz_s;
  logic                 blank_s;
  logic [ROM_AW-1:0]    addr_s;

  // S0: locate the pixel inside the score box and pick its digit slot.
  always_comb begin
    in_box_s = ({22'd0, DrawX} >= 32'(ORIGIN_X)) &&
               ({22'd0, DrawX} <  32'(ORIGIN_X + DIGITS * GLYPH_W)) &&
               ({22'd0, DrawY} >= 32'(ORIGIN_Y)) &&
               ({22'd0, DrawY} <  32'(ORIGIN_Y + GLYPH_H));
    dx_s   = DrawX - 10'(ORIGIN_X);
    dy_s   = DrawY - 10'(ORIGIN_Y);
    slot_s = {SLOT_W{1'b0}};
    base_s = 10'd0;
    // Comparator chain instead of a divider: the last threshold passed wins.
    for (int k = 1; k < DIGITS; k++) begin
      if (dx_s >= 10'(k * GLYPH_W)) begin
        slot_s = SLOT_W'(k);
        base_s = 10'(k * GLYPH_W);
      end else begin
        slot_s = slot_s;
        base_s = base_s;
      end
    end
    col_s   = dx_s - base_s;
    digit_s = 4'd0;
    blank_s = 1'b0;
    lz_s    = 1'b1;
    // Slot 0 is the MS digit; blank while every digit so far is zero, except the LS slot.
    for (int k = 0; k < DIGITS; k++) begin
      lz_s = lz_s & (digits_r[4*(DIGITS-1-k) +: 4] == 4'd0);
      if (slot_s == SLOT_W'(k)) begin
        digit_s = digits_r[4*(DIGITS-1-k) +: 4];
        blank_s = lz_s & (k != DIGITS - 1);
      end else begin
        digit_s = digit_s;
        blank_s = blank_s;
      end
    end
    addr_s = ROM_AW'(GLYPH_BASE)
           + ROM_AW'(digit_s) * ROM_AW'(GLYPH_W * GLYPH_H)
           + ROM_AW'(dy_s) * ROM_AW'(GLYPH_W)
           + ROM_AW'(col_s);
  end

  logic [ROM_AW-1:0] rom_addr_r;
  logic              in_box_d_r;
  logic              blank_d_r;
  logic              pixel_on_r;
  logic [2:0]        pixel_color_r;
  logic              pix_on_s;

  assign pix_on_s = in_box_d_r & ~blank_d_r & (rom_data != 3'd0);

  // S1 registers the ROM address; S2 registers the opaque/colour decision.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_r    <= {ROM_AW{1'b0}};
      in_box_d_r    <= 1'b0;
      blank_d_r     <= 1'b0;
      pixel_on_r    <= 1'b0;
      pixel_color_r <= 3'd0;
    end else begin
      rom_addr_r    <= in_box_s ? addr_s : {ROM_AW{1'b0}};
      in_box_d_r    <= in_box_s;
      blank_d_r     <= blank_s;
      pixel_on_r    <= pix_on_s;
      pixel_color_r <= pix_on_s ? rom_data : 3'd0;
    end
  end

  assign busy        = busy_r;
  assign digits_out  = digits_r;
  assign rom_addr    = rom_addr_r;
  assign pixel_on    = pixel_on_r;
  assign pixel_color = pixel_color_r;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed self-checking bench for score_digit_sequencer.
module tb_score_digit_sequencer;

  localparam int OX = 480;
  localparam int OY = 16;

  logic        Clk;
  logic        Reset;
  logic [13:0] score_in;
  logic        score_load;
  logic        frame_start;
  logic        busy;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic        pixel_on;
  logic [2:0]  pixel_color;
  logic [15:0] digits_out;

  int vectors;
  int miscompares;

  score_digit_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .score_in    (score_in),
    .score_load  (score_load),
    .frame_start (frame_start),
    .busy        (busy),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_on    (pixel_on),
    .pixel_color (pixel_color),
    .digits_out  (digits_out)
  );

  // ROM stand-in: data lines up with the registered address; low bits 101 read transparent.
  assign rom_data = rom_addr[2:0] ^ 3'd5;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_score(input logic [13:0] v);
    score_in   = v;
    score_load = 1'b1;
    tick();
    score_load = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; score_in = 14'd0; score_load = 1'b0; frame_start = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    tick(); tick();
    vectors++; if (digits_out !== 16'h0000) begin miscompares++; $display("FAIL reset_digits: got %h want 0000", digits_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    vectors++; if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL reset_pixel_on: got %b want 0", pixel_on); end
    vectors++; if (pixel_color !== 3'd0) begin miscompares++; $display("FAIL reset_pixel_color: got %0d want 0", pixel_color); end
    Reset = 1'b0;
    tick();
    load_score(14'd1234);
    repeat (5) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_mid_convert: got %b want 1", busy); end
    #2 Reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    vectors++; if (digits_out !== 16'h0000) begin miscompares++; $display("FAIL async_reset_digits: got %h want 0000", digits_out); end
    tick();
    Reset = 1'b0;
    tick();
    // Score 0: only the LS slot shows glyph '0' (col 2, row 5 -> addr 52, data 1).
    DrawX = 10'(OX + 32); DrawY = 10'(OY + 5);
    tick();
    vectors++; if (rom_addr !== 12'd52) begin miscompares++; $display("FAIL zero_rom_addr: got %0d want 52", rom_addr); end
    tick();
    vectors++; if (pixel_on !== 1'b1) begin miscompares++; $display("FAIL zero_pixel_on: got %b want 1", pixel_on); end
    vectors++; if (pixel_color !== 3'd1) begin miscompares++; $display("FAIL zero_pixel_color: got %0d want 1", pixel_color); end
    for (int s = 0; s < 3; s++) begin
      DrawX = 10'(OX + s * 10 + 2);
      tick(); tick();
      vectors++; if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL zero_blank_slot%0d: got %b want 0", s, pixel_on); end
    end
  endtask

  task automatic test_convert();
    load_score(14'd1234);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_load: got %b want 1", busy); end
    for (int c = 1; c < 30; c++) begin
      tick();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_cycle%0d: got %b want 1", c, busy); end
    end
    pulse_frame();
    vectors++; if (digits_out !== 16'h1234) begin miscompares++; $display("FAIL commit_1234: got %h want 1234", digits_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_commit: got %b want 0", busy); end
  endtask

  task automatic test_saturate();
    load_score(14'd12000);
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h9999) begin miscompares++; $display("FAIL saturate_12000: got %h want 9999", digits_out); end
    load_score(14'd9999);
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h9999) begin miscompares++; $display("FAIL exact_9999: got %h want 9999", digits_out); end
    load_score(14'd10000);
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h9999) begin miscompares++; $display("FAIL saturate_10000: got %h want 9999", digits_out); end
  endtask

  task automatic test_back_to_back();
    load_score(14'd42);
    repeat (4) tick();
    load_score(14'd777);
    repeat (14) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h0042) begin miscompares++; $display("FAIL first_commit_42: got %h want 0042", digits_out); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_pending: got %b want 1", busy); end
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h0777) begin miscompares++; $display("FAIL second_commit_777: got %h want 0777", digits_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_pending: got %b want 0", busy); end
    // frame_start during CONVERT is ignored.
    load_score(14'd56);
    tick(); tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h0777) begin miscompares++; $display("FAIL frame_in_convert: got %h want 0777", digits_out); end
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h0056) begin miscompares++; $display("FAIL commit_56: got %h want 0056", digits_out); end
    // Load on the commit edge becomes the next conversion.
    load_score(14'd9);
    repeat (20) tick();
    score_in = 14'd3; score_load = 1'b1; frame_start = 1'b1;
    tick();
    score_load = 1'b0; frame_start = 1'b0;
    vectors++; if (digits_out !== 16'h0009) begin miscompares++; $display("FAIL commit_9: got %h want 0009", digits_out); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_same_edge_load: got %b want 1", busy); end
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h0003) begin miscompares++; $display("FAIL commit_3: got %h want 0003", digits_out); end
  endtask

  task automatic test_render();
    load_score(14'd42);
    repeat (20) tick();
    pulse_frame();
    vectors++; if (digits_out !== 16'h0042) begin miscompares++; $display("FAIL render_digits: got %h want 0042", digits_out); end
    // Slot 2 digit 4, col 2, row 3: 800 + 30 + 2 = 832, data 5.
    DrawX = 10'(OX + 22); DrawY = 10'(OY + 3);
    tick();
    vectors++; if (rom_addr !== 12'd832) begin miscompares++; $display("FAIL addr_832: got %0d want 832", rom_addr); end
    tick();
    vectors++; if (pixel_on !== 1'b1) begin miscompares++; $display("FAIL on_832: got %b want 1", pixel_on); end
    vectors++; if (pixel_color !== 3'd5) begin miscompares++; $display("FAIL color_832: got %0d want 5", pixel_color); end
    // Slot 3 digit 2, col 2, row 3: 400 + 30 + 2 = 432, data 5.
    DrawX = 10'(OX + 32);
    tick();
    vectors++; if (rom_addr !== 12'd432) begin miscompares++; $display("FAIL addr_432: got %0d want 432", rom_addr); end
    tick();
    vectors++; if (pixel_color !== 3'd5) begin miscompares++; $display("FAIL color_432: got %0d want 5", pixel_color); end
    // Col 7 -> addr 837, data 0 is transparent.
    DrawX = 10'(OX + 27);
    tick(); tick();
    vectors++; if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL transparent_837: got %b want 0", pixel_on); end
    // Slot 1 is a leading zero.
    DrawX = 10'(OX + 12);
    tick(); tick();
    vectors++; if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL leading_zero: got %b want 0", pixel_on); end
    vectors++; if (pixel_color !== 3'd0) begin miscompares++; $display("FAIL leading_zero_color: got %0d want 0", pixel_color); end
    // Right edge, left edge and bottom edge are outside the box.
    DrawX = 10'(OX + 40);
    tick();
    vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL right_edge_addr: got %0d want 0", rom_addr); end
    tick();
    vectors++; if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL right_edge_on: got %b want 0", pixel_on); end
    DrawX = 10'(OX - 1);
    tick();
    vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL left_edge_addr: got %0d want 0", rom_addr); end
    DrawX = 10'(OX + 22); DrawY = 10'(OY + 20);
    tick();
    vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL bottom_edge_addr: got %0d want 0", rom_addr); end
    tick();
    vectors++; if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL bottom_edge_on: got %b want 0", pixel_on); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_convert();
    test_saturate();
    test_back_to_back();
    test_render();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
